// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic timing sequencer.
// Light encodings, timing_state indices and the step successor function.
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } light_e;

    typedef logic [3:0] timing_state_t;

    localparam timing_state_t TS_NS_GREEN  = 4'd0;
    localparam timing_state_t TS_NS_YELLOW = 4'd4;
    localparam timing_state_t TS_EW_GREEN  = 4'd5;
    localparam timing_state_t TS_EW_YELLOW = 4'd9;
    localparam timing_state_t TS_WALK      = 4'd10;
    localparam timing_state_t TS_ALL_RED   = 4'd15;

    // Successor of a timing state; walk is only inserted after the last
    // yellow when a pedestrian is waiting. Anything unexpected restarts.
    function automatic timing_state_t next_ts(
        input timing_state_t ts,
        input logic          ped
    );
        timing_state_t r;
        r = TS_NS_GREEN;
        if (ts < TS_EW_YELLOW) begin
            r = ts + 4'd1;
        end else if (ts == TS_EW_YELLOW) begin
            r = ped ? TS_WALK : TS_NS_GREEN;
        end
        return r;
    endfunction

endpackage

// File: rtl/traffic_dwell_timer.sv
// Dwell counter: counts 0..limit_i on en, wraps to 0 at terminal count.
// Ports: clk, rst (sync), en, clr, limit_i (terminal value), tc_o.
module traffic_dwell_timer #(
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [CW-1:0] limit_i,
    output logic          tc_o
);
    import traffic_pkg::*;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o = (cnt_q == limit_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_timing_sequencer.sv
// Generates timing_state 0..9 (+ walk 10 on request) for the light decoder.
// Ports: clk, rst, en, ped_req, emergency in; timing_state, ped_ack,
// step_pulse, cycle_done out. Macro TRAFFIC_EMERGENCY_EN enables all-red.
module traffic_timing_sequencer
    import traffic_pkg::*;
#(
    parameter int STEP_TICKS = 50,
    parameter int WALK_TICKS = 100
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          ped_req,
    input  logic          emergency,
    output timing_state_t timing_state,
    output logic          ped_ack,
    output logic          step_pulse,
    output logic          cycle_done
);

    localparam int MAXT = (STEP_TICKS > WALK_TICKS) ? STEP_TICKS
                                                    : WALK_TICKS;
    localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

    timing_state_t state_q, state_d, nxt;
    logic          step_q, step_d;
    logic          pend_q, pend_d;
    logic [CW-1:0] limit;
    logic          tmr_en, tmr_clr, tc;

    traffic_dwell_timer #(
        .CW(CW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (tmr_en),
        .clr     (tmr_clr),
        .limit_i (limit),
        .tc_o    (tc)
    );

`ifndef TRAFFIC_EMERGENCY_EN
    logic unused_emergency;
    assign unused_emergency = emergency;
`endif

    always_comb begin
        limit   = (state_q == TS_WALK) ? CW'(WALK_TICKS - 1)
                                       : CW'(STEP_TICKS - 1);
        // A request arriving on the 9->10 decision edge counts too.
        nxt     = next_ts(state_q, pend_q | ped_req);
        state_d = state_q;
        step_d  = 1'b0;
        pend_d  = pend_q | ped_req;
        tmr_en  = en;
        tmr_clr = 1'b0;
        if (en && tc) begin
            state_d = nxt;
            step_d  = 1'b1;
            if (nxt == TS_WALK) begin
                pend_d = 1'b0;
            end
        end
`ifdef TRAFFIC_EMERGENCY_EN
        // Emergency overrides the enable; the request latch survives it.
        if (emergency) begin
            state_d = TS_ALL_RED;
            step_d  = 1'b0;
            pend_d  = pend_q | ped_req;
            tmr_en  = 1'b0;
            tmr_clr = 1'b1;
        end else if (state_q == TS_ALL_RED) begin
            state_d = TS_NS_GREEN;
            step_d  = 1'b1;
            pend_d  = pend_q | ped_req;
            tmr_en  = 1'b0;
            tmr_clr = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TS_NS_GREEN;
            step_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            pend_q  <= pend_d;
        end
    end

    assign timing_state = state_q;
    assign step_pulse   = step_q;
    assign ped_ack      = step_q && (state_q == TS_WALK);
    assign cycle_done   = step_q && (state_q == TS_NS_GREEN);

endmodule

// File: tb/tb_traffic_timing_sequencer.sv
// Directed bench for traffic_timing_sequencer (STEP_TICKS=2, WALK_TICKS=3).
// Covers free run, pedestrian insertion, enable freeze, reset and emergency.
module tb_traffic_timing_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       ped_req;
    logic       emergency;
    logic [3:0] timing_state;
    logic       ped_ack;
    logic       step_pulse;
    logic       cycle_done;

    int npass = 0;
    int ntot  = 0;

    traffic_timing_sequencer #(
        .STEP_TICKS(2),
        .WALK_TICKS(3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .ped_req      (ped_req),
        .emergency    (emergency),
        .timing_state (timing_state),
        .ped_ack      (ped_ack),
        .step_pulse   (step_pulse),
        .cycle_done   (cycle_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input int s, input bit sp,
                           input bit ak, input bit cd);
        chk({tag, ".state"}, 32'(timing_state), 32'(s));
        chk({tag, ".step"}, 32'(step_pulse), 32'(sp));
        chk({tag, ".ack"}, 32'(ped_ack), 32'(ak));
        chk({tag, ".cdone"}, 32'(cycle_done), 32'(cd));
    endtask

    // Run relative edges k0+1..k1 of a round that began when state 0 was
    // entered (edge 0). Round length is 20 edges, 23 with a walk phase.
    // ped_req is high in the cycles after edges p1 and p2.
    task automatic seg(input string tag, input int k0, input int k1,
                       input bit walk, input int p1, input int p2);
        int n;
        int s;
        bit sp;
        n = walk ? 23 : 20;
        for (int k = k0 + 1; k <= k1; k++) begin
            ped_req = ((k - 1) == p1) || ((k - 1) == p2);
            tick();
            ped_req = 1'b0;
            if (k < 20) begin
                s  = k / 2;
                sp = (k % 2) == 0;
            end else if (walk && k < 23) begin
                s  = 10;
                sp = (k == 20);
            end else begin
                s  = 0;
                sp = 1'b1;
            end
            chk_all($sformatf("%s.k%0d", tag, k), s, sp,
                    walk && k == 20, k == n);
        end
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        ped_req   = 1'b0;
        emergency = 1'b0;
        repeat (3) tick();
        chk_all("reset", 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        en  = 1'b1;

        // free run, no walk
        seg("run", 0, 20, 1'b0, -1, -1);

        // request pulse in state 3, walk appears after 9
        seg("ped", 0, 23, 1'b1, 6, -1);
        seg("ped_clr", 0, 20, 1'b0, -1, -1);

        // request on the 9->10 edge and again inside walk
        seg("edge", 0, 23, 1'b1, 19, 20);
        seg("again", 0, 23, 1'b1, -1, -1);
        seg("idle", 0, 20, 1'b0, -1, -1);

        // freeze in state 6 at tick 1, request latched while frozen
        seg("frz_a", 0, 13, 1'b0, -1, -1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ped_req = (i == 2);
            tick();
            ped_req = 1'b0;
            chk_all($sformatf("frz%0d", i), 6, 1'b0, 1'b0, 1'b0);
        end
        en = 1'b1;
        seg("frz_b", 13, 23, 1'b1, -1, -1);

        // reset while in walk with a fresh request pending
        seg("rst_a", 0, 20, 1'b1, 5, -1);
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        chk_all("rst_w", 10, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all("rst_r", 0, 1'b0, 1'b0, 1'b0);
        seg("rst_b", 0, 20, 1'b0, -1, -1);

        // emergency held 4 cycles in state 5
        seg("emg_a", 0, 10, 1'b0, -1, -1);
`ifdef TRAFFIC_EMERGENCY_EN
        emergency = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all($sformatf("emg%0d", i), 15, 1'b0, 1'b0, 1'b0);
        end
        emergency = 1'b0;
        tick();
        chk_all("emg_end", 0, 1'b1, 1'b0, 1'b1);
        seg("emg_b", 0, 20, 1'b0, -1, -1);
`else
        emergency = 1'b1;
        seg("emg_b", 10, 14, 1'b0, -1, -1);
        emergency = 1'b0;
        seg("emg_c", 14, 20, 1'b0, -1, -1);
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
